// File: rtl/tf_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tf_row_buffer
// Purpose  : Ping-pong row collector between the twiddle-factor generator and
//            the NTT array. One bank fills from generator write beats while
//            the other drains as a valid/ready stream of DEPTH entries.
// Revision : 1.0  initial release
// ============================================================================
module tf_row_buffer #(
    parameter int MM_NUM = 4,
    parameter int DW     = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 first_start,
    input  logic                 vld,
    input  logic [AW-1:0]        addr_w,
    input  logic [MM_NUM*DW-1:0] tf_in,
    input  logic                 done_row,
    input  logic                 done,
    output logic                 can_start,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [MM_NUM*DW-1:0] out_data,
    output logic [AW-1:0]        out_addr,
    output logic [1:0]           out_row,
    output logic                 out_last,
    output logic                 all_done,
    output logic                 err_ovf,
    output logic                 err_len
);

    localparam int GW = MM_NUM * DW;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        BK_EMPTY    = 2'd0,
        BK_FILLING  = 2'd1,
        BK_FULL     = 2'd2,
        BK_DRAINING = 2'd3
    } bank_st_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bank_st_e          bank_st_q [2];
    bank_st_e          bank_st_d [2];
    logic [CW-1:0]     wcnt_q    [2];
    logic [CW-1:0]     wcnt_d    [2];
    logic [1:0]        tag_q     [2];
    logic [1:0]        tag_d     [2];

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        row_cnt_q, row_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_len_q, err_len_d;
    logic              done_flag_q, done_flag_d;
    logic              all_done_q, all_done_d;
    logic              can_start_q, can_start_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic              issued_all_q, issued_all_d;

    // Read pipeline: memory output register and the beat it belongs to
    logic [GW-1:0]     mem_q [2][DEPTH];
    logic [GW-1:0]     rd_data_q;
    logic              rd_vld_q;
    logic [AW-1:0]     rd_addr_q;
    logic [1:0]        rd_tag_q;
    logic              rd_last_q;

    // Two-entry output skid buffer; entry 0 is the presented beat
    logic [GW-1:0]     ent_data_q [2];
    logic [AW-1:0]     ent_addr_q [2];
    logic [1:0]        ent_row_q  [2];
    logic              ent_last_q [2];
    logic [1:0]        fcnt_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    bank_st_e          w_wr_st;
    bank_st_e          w_rd_st;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic [1:0]        w_row_base;
    logic [CW-1:0]     w_cnt_incl;

    assign w_wr_st  = bank_st_q[wr_ptr_q];
    assign w_rd_st  = bank_st_q[rd_ptr_q];
    assign w_pop    = out_vld && out_rdy;
    assign w_accept = vld && ((w_wr_st == BK_EMPTY) || (w_wr_st == BK_FILLING));
    assign w_drop   = vld && !w_accept;

    // Occupancy the skid buffer will hold once the in-flight read lands;
    // a new read is only issued if it is guaranteed a free slot.
    assign w_occ    = {1'b0, fcnt_q} + {2'b00, rd_vld_q} - {2'b00, w_pop};
    assign w_issue  = (w_occ < 3'd2) &&
                      ((w_rd_st == BK_FULL) ||
                       ((w_rd_st == BK_DRAINING) && !issued_all_q));

    assign w_row_base = first_start ? 2'd0 : row_cnt_q;
    assign w_cnt_incl = ((w_wr_st == BK_EMPTY) ? {CW{1'b0}} : wcnt_q[wr_ptr_q]) + CW'(1);

    // Next-state for bank FSMs, pointers, counters and status flags
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_d[b] = bank_st_q[b];
            wcnt_d[b]    = wcnt_q[b];
            tag_d[b]     = tag_q[b];
        end
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_idx_d     = rd_idx_q;
        issued_all_d = issued_all_q;
        row_cnt_d    = w_row_base;
        err_ovf_d    = first_start ? 1'b0 : err_ovf_q;
        err_len_d    = first_start ? 1'b0 : err_len_q;
        done_flag_d  = (first_start ? 1'b0 : done_flag_q) | done;

        // Drain side: only ever touches a FULL/DRAINING bank
        if (w_issue) begin
            bank_st_d[rd_ptr_q] = BK_DRAINING;
            rd_idx_d            = rd_idx_q + AW'(1);
            if (rd_idx_q == AW'(DEPTH - 1)) begin
                issued_all_d = 1'b1;
            end
        end
        if (w_pop && out_last) begin
            bank_st_d[rd_ptr_q] = BK_EMPTY;
            rd_ptr_d            = ~rd_ptr_q;
            rd_idx_d            = '0;
            issued_all_d        = 1'b0;
        end

        // Fill side: only ever touches an EMPTY/FILLING bank
        if (w_accept) begin
            wcnt_d[wr_ptr_q] = w_cnt_incl;
            if (w_wr_st == BK_EMPTY) begin
                tag_d[wr_ptr_q]     = w_row_base;
                bank_st_d[wr_ptr_q] = BK_FILLING;
            end
            if (done_row) begin
                bank_st_d[wr_ptr_q] = BK_FULL;
                wr_ptr_d            = ~wr_ptr_q;
                row_cnt_d           = w_row_base + 2'd1;
                if (w_cnt_incl != CW'(DEPTH)) begin
                    err_len_d = 1'b1;
                end
            end
        end
        if (w_drop) begin
            err_ovf_d = 1'b1;
        end

        all_done_d = done_flag_d && (bank_st_d[0] == BK_EMPTY) && (bank_st_d[1] == BK_EMPTY);
        if (all_done_d) begin
            done_flag_d = 1'b0;
        end
        can_start_d = (bank_st_d[wr_ptr_d] == BK_EMPTY);
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b] <= BK_EMPTY;
                wcnt_q[b]    <= '0;
                tag_q[b]     <= '0;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            rd_idx_q     <= '0;
            issued_all_q <= 1'b0;
            row_cnt_q    <= '0;
            err_ovf_q    <= 1'b0;
            err_len_q    <= 1'b0;
            done_flag_q  <= 1'b0;
            all_done_q   <= 1'b0;
            can_start_q  <= 1'b1;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b] <= bank_st_d[b];
                wcnt_q[b]    <= wcnt_d[b];
                tag_q[b]     <= tag_d[b];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_idx_q     <= rd_idx_d;
            issued_all_q <= issued_all_d;
            row_cnt_q    <= row_cnt_d;
            err_ovf_q    <= err_ovf_d;
            err_len_q    <= err_len_d;
            done_flag_q  <= done_flag_d;
            all_done_q   <= all_done_d;
            can_start_q  <= can_start_d;
        end
    end

    // Bank storage: write at the beat edge, synchronous read on issue
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q][addr_w] <= tf_in;
        end
        if (w_issue) begin
            rd_data_q <= mem_q[rd_ptr_q][rd_idx_q];
        end
    end

    // Side-band information travelling alongside the memory read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_tag_q  <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q <= w_issue;
            if (w_issue) begin
                rd_addr_q <= rd_idx_q;
                rd_tag_q  <= tag_q[rd_ptr_q];
                rd_last_q <= (rd_idx_q == AW'(DEPTH - 1));
            end
        end
    end

    // Skid buffer: pushes arriving reads, pops on handshake, head held on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < 2; e++) begin
                ent_data_q[e] <= '0;
                ent_addr_q[e] <= '0;
                ent_row_q[e]  <= '0;
                ent_last_q[e] <= 1'b0;
            end
            fcnt_q <= 2'd0;
        end else begin
            if (w_pop) begin
                ent_data_q[0] <= ent_data_q[1];
                ent_addr_q[0] <= ent_addr_q[1];
                ent_row_q[0]  <= ent_row_q[1];
                ent_last_q[0] <= ent_last_q[1];
            end
            if (rd_vld_q) begin
                if ((fcnt_q == 2'd0) || ((fcnt_q == 2'd1) && w_pop)) begin
                    ent_data_q[0] <= rd_data_q;
                    ent_addr_q[0] <= rd_addr_q;
                    ent_row_q[0]  <= rd_tag_q;
                    ent_last_q[0] <= rd_last_q;
                end else begin
                    ent_data_q[1] <= rd_data_q;
                    ent_addr_q[1] <= rd_addr_q;
                    ent_row_q[1]  <= rd_tag_q;
                    ent_last_q[1] <= rd_last_q;
                end
            end
            fcnt_q <= fcnt_q + {1'b0, rd_vld_q} - {1'b0, w_pop};
        end
    end

    assign out_vld   = (fcnt_q != 2'd0);
    assign out_data  = ent_data_q[0];
    assign out_addr  = ent_addr_q[0];
    assign out_row   = ent_row_q[0];
    assign out_last  = ent_last_q[0];
    assign can_start = can_start_q;
    assign all_done  = all_done_q;
    assign err_ovf   = err_ovf_q;
    assign err_len   = err_len_q;

endmodule
`default_nettype wire

// File: tb/tb_tf_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tf_row_buffer
// Purpose  : Directed self-checking bench for tf_row_buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_tf_row_buffer;

    localparam int MM_NUM = 4;
    localparam int DW     = 16;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int GW     = MM_NUM * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          first_start;
    logic          vld;
    logic [AW-1:0] addr_w;
    logic [GW-1:0] tf_in;
    logic          done_row;
    logic          done;
    logic          can_start;
    logic          out_vld;
    logic          out_rdy;
    logic [GW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [1:0]    out_row;
    logic          out_last;
    logic          all_done;
    logic          err_ovf;
    logic          err_len;

    int n_tests = 0;
    int n_fail  = 0;
    int ad_cnt  = 0;

    tf_row_buffer #(.MM_NUM(MM_NUM), .DW(DW), .DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .first_start (first_start),
        .vld         (vld),
        .addr_w      (addr_w),
        .tf_in       (tf_in),
        .done_row    (done_row),
        .done        (done),
        .can_start   (can_start),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_row     (out_row),
        .out_last    (out_last),
        .all_done    (all_done),
        .err_ovf     (err_ovf),
        .err_len     (err_len)
    );

    always #5 clk = ~clk;

    // Count every cycle all_done is seen high
    always @(negedge clk) begin
        if (all_done) ad_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [GW-1:0] pat(input logic [7:0] seed, input logic [7:0] a);
        return {4{seed, a}};
    endfunction

    // Write nbeats beats at addresses 0..nbeats-1, done_row on the last one
    task automatic write_row(input logic [7:0] seed, input int nbeats, input bit fs);
        for (int i = 0; i < nbeats; i++) begin
            vld         = 1'b1;
            addr_w      = 8'(i);
            tf_in       = pat(seed, 8'(i));
            done_row    = (i == nbeats - 1);
            first_start = fs && (i == 0);
            @(posedge clk); #1;
        end
        vld         = 1'b0;
        done_row    = 1'b0;
        first_start = 1'b0;
    endtask

    // Consume n_stop beats, checking order, tag, last flag, data and stall hold
    task automatic drain(input string tag, input logic [1:0] exp_row, input logic [7:0] seed,
                         input int n_data, input bit rnd, input int n_stop, output int cycles);
        int            idx;
        int            bad;
        int            stall_bad;
        bit            stalled;
        logic [GW-1:0] pd;
        logic [AW-1:0] pa;
        logic [1:0]    pr;
        logic          pl;
        idx = 0; bad = 0; stall_bad = 0; stalled = 1'b0; cycles = 0;
        pd = '0; pa = '0; pr = '0; pl = 1'b0;
        out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (idx < n_stop && cycles < 4000) begin
            @(negedge clk);
            if (stalled) begin
                if (out_vld !== 1'b1 || out_data !== pd || out_addr !== pa ||
                    out_row !== pr || out_last !== pl) stall_bad++;
            end
            if (out_vld && out_rdy) begin
                if (out_addr !== 8'(idx) || out_row !== exp_row ||
                    out_last !== (idx == DEPTH - 1)) bad++;
                if (idx < n_data && out_data !== pat(seed, 8'(idx))) bad++;
                idx++;
            end
            stalled = out_vld && !out_rdy;
            pd = out_data; pa = out_addr; pr = out_row; pl = out_last;
            @(posedge clk); #1;
            cycles++;
            out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check_eq({tag, " beats"}, 64'(idx), 64'(n_stop));
        check_eq({tag, " order/data"}, 64'(bad), 64'd0);
        if (rnd) check_eq({tag, " stall hold"}, 64'(stall_bad), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; first_start = 1'b0; vld = 1'b0; addr_w = '0; tf_in = '0;
        done_row = 1'b0; done = 1'b0; out_rdy = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset values
        check_eq("rst out_vld",   64'(out_vld),   64'd0);
        check_eq("rst out_data",  64'(out_data),  64'd0);
        check_eq("rst out_addr",  64'(out_addr),  64'd0);
        check_eq("rst out_row",   64'(out_row),   64'd0);
        check_eq("rst out_last",  64'(out_last),  64'd0);
        check_eq("rst can_start", 64'(can_start), 64'd1);
        check_eq("rst all_done",  64'(all_done),  64'd0);
        check_eq("rst err_ovf",   64'(err_ovf),   64'd0);
        check_eq("rst err_len",   64'(err_len),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single row, tf = {4{addr}}, latency from closing edge and contiguity
        out_rdy = 1'b1;
        write_row(8'h00, DEPTH, 1'b0);
        check_eq("t1 can_start after close", 64'(can_start), 64'd1);
        check_eq("t1 vld at T", 64'(out_vld), 64'd0);
        @(posedge clk); #1;
        check_eq("t1 vld at T+1", 64'(out_vld), 64'd0);
        @(posedge clk); #1;
        check_eq("t1 vld at T+2", 64'(out_vld), 64'd1);
        check_eq("t1 first addr", 64'(out_addr), 64'd0);
        drain("t1", 2'd0, 8'h00, DEPTH, 1'b0, DEPTH, cyc);
        check_eq("t1 contiguous cycles", 64'(cyc), 64'(DEPTH));
        check_eq("t1 err_ovf", 64'(err_ovf), 64'd0);
        check_eq("t1 err_len", 64'(err_len), 64'd0);

        // Random backpressure, row tag 1
        out_rdy = 1'b0;
        write_row(8'h11, DEPTH, 1'b0);
        drain("t2", 2'd1, 8'h11, DEPTH, 1'b1, DEPTH, cyc);

        // Two rows parked, overflow beat, then ordered drain
        out_rdy = 1'b0;
        first_start = 1'b1;
        @(posedge clk); #1;
        first_start = 1'b0;
        write_row(8'h22, DEPTH, 1'b0);
        write_row(8'h33, DEPTH, 1'b0);
        repeat (4) @(posedge clk); #1;
        check_eq("t3 can_start both full", 64'(can_start), 64'd0);
        check_eq("t3 err_ovf before", 64'(err_ovf), 64'd0);
        write_row(8'h44, 1, 1'b0);
        check_eq("t3 err_ovf set", 64'(err_ovf), 64'd1);
        check_eq("t3 can_start still 0", 64'(can_start), 64'd0);
        check_eq("t3 err_len untouched", 64'(err_len), 64'd0);
        drain("t3 rowA", 2'd0, 8'h22, DEPTH, 1'b0, DEPTH, cyc);
        check_eq("t3 can_start after drain", 64'(can_start), 64'd1);
        drain("t3 rowB", 2'd1, 8'h33, DEPTH, 1'b0, DEPTH, cyc);
        repeat (3) @(posedge clk); #1;
        check_eq("t3 no extra beats", 64'(out_vld), 64'd0);

        // Short row (100 beats) opened together with first_start
        write_row(8'h55, 100, 1'b1);
        check_eq("t4 err_len", 64'(err_len), 64'd1);
        check_eq("t4 err_ovf cleared", 64'(err_ovf), 64'd0);
        drain("t4", 2'd0, 8'h55, 100, 1'b0, DEPTH, cyc);

        // Four rows, done, all_done pulse
        first_start = 1'b1;
        @(posedge clk); #1;
        first_start = 1'b0;
        check_eq("t5 err_len cleared", 64'(err_len), 64'd0);
        for (int r = 0; r < 3; r++) begin
            write_row(8'(8'h60 + r), DEPTH, 1'b0);
            drain($sformatf("t5 row%0d", r), 2'(r), 8'(8'h60 + r), DEPTH, 1'b0, DEPTH, cyc);
        end
        write_row(8'h63, DEPTH, 1'b0);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        check_eq("t5 all_done early", 64'(all_done), 64'd0);
        drain("t5 row3", 2'd3, 8'h63, DEPTH, 1'b0, DEPTH, cyc);
        check_eq("t5 all_done pulse", 64'(all_done), 64'd1);
        @(posedge clk); #1;
        check_eq("t5 all_done drop", 64'(all_done), 64'd0);
        check_eq("t5 all_done count", 64'(ad_cnt), 64'd1);

        // Reset during a drain at beat 37, then a fresh row
        write_row(8'h80, DEPTH, 1'b0);
        drain("t6 pre", 2'd0, 8'h80, DEPTH, 1'b0, 37, cyc);
        rst = 1'b1;
        #1;
        check_eq("t6 rst out_vld",   64'(out_vld),   64'd0);
        check_eq("t6 rst out_addr",  64'(out_addr),  64'd0);
        check_eq("t6 rst out_data",  64'(out_data),  64'd0);
        check_eq("t6 rst out_last",  64'(out_last),  64'd0);
        check_eq("t6 rst can_start", 64'(can_start), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("t6 idle after rst", 64'(out_vld), 64'd0);
        write_row(8'h90, DEPTH, 1'b0);
        drain("t6 post", 2'd0, 8'h90, DEPTH, 1'b0, DEPTH, cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
